// File: rtl/mips_isa_pkg.sv
// Shared MIPS subset encoding constants for the instruction encoder/loader and decode control.
// Opcode/funct values, field bit positions and the symbolic request operation enum.
package mips_isa_pkg;

  typedef enum logic [3:0] {
    OP_ADDI = 4'd0,
    OP_BLTZ = 4'd1,
    OP_J    = 4'd2,
    OP_LW   = 4'd3,
    OP_SW   = 4'd4,
    OP_SUBU = 4'd5,
    OP_NOR  = 4'd6,
    OP_SLTU = 4'd7,
    OP_JR   = 4'd8
  } enc_op_t;

  localparam logic [5:0] OPC_RTYPE  = 6'h00;
  localparam logic [5:0] OPC_REGIMM = 6'h01;
  localparam logic [5:0] OPC_J      = 6'h02;
  localparam logic [5:0] OPC_ADDI   = 6'h08;
  localparam logic [5:0] OPC_LW     = 6'h23;
  localparam logic [5:0] OPC_SW     = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;

  function automatic logic [31:0] j_word(input logic [25:0] target);
    return {OPC_J, target};
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: symbolic operation plus register/immediate fields -> 32-bit MIPS word.
// Unknown operation codes yield a zero word with illegal asserted.
module instr_field_pack
  import mips_isa_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  function automatic logic [31:0] r_word(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                         input logic [4:0] rd_f, input logic [5:0] funct);
    return {OPC_RTYPE, rs_f, rt_f, rd_f, 5'd0, funct};
  endfunction

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_ADDI: word = {OPC_ADDI, rs, rt, imm};
      OP_BLTZ: word = {OPC_REGIMM, rs, 5'd0, imm};
      OP_J:    word = j_word(target);
      OP_LW:   word = {OPC_LW, rs, rt, imm};
      OP_SW:   word = {OPC_SW, rs, rt, imm};
      OP_SUBU: word = r_word(rs, rt, rd, FN_SUBU);
      OP_NOR:  word = r_word(rs, rt, rd, FN_NOR);
      OP_SLTU: word = r_word(rs, rt, rd, FN_SLTU);
      // jr only names a source register; rt and rd are architecturally zero
      OP_JR:   word = r_word(rs, 5'd0, 5'd0, FN_JR);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts symbolic instruction requests, encodes them and writes them sequentially into imem,
// then releases the CPU. Define ENC_HALT_PAD_EN to append a 'j self' halt word on done.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_op,
  input  logic [4:0]    req_rs,
  input  logic [4:0]    req_rt,
  input  logic [4:0]    req_rd,
  input  logic [15:0]   req_imm,
  input  logic [25:0]   req_target,
  input  logic          done,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_run,
  output logic          err_op,
  output logic          full
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PAD, S_RUN} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          full_q, full_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   enc_word;
  logic          enc_illegal;
  logic          accept;

  instr_field_pack u_pack (
    .op      (req_op),
    .rs      (req_rs),
    .rt      (req_rt),
    .rd      (req_rd),
    .imm     (req_imm),
    .target  (req_target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign req_ready  = (state_q == S_LOAD) && !full_q;
  assign accept     = req_valid && req_ready;
  // A restart drops the CPU out of run in the very cycle start is seen
  assign cpu_run    = (state_q == S_RUN) && !start;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign err_op     = err_q;
  assign full       = full_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    full_d   = full_q;
    err_d    = err_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (start) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
          err_d    = 1'b0;
          full_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (enc_illegal) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            addr_d  = wr_ptr_q;
            wdata_d = enc_word;
            if (wr_ptr_q == LAST_ADDR) full_d = 1'b1;
            else wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end
        // full_d already reflects a same-cycle final write, so the pad is skipped then
        if (done) begin
`ifdef ENC_HALT_PAD_EN
          state_d = full_d ? S_RUN : S_PAD;
`else
          state_d = S_RUN;
`endif
        end
      end
      S_PAD: begin
        we_d    = 1'b1;
        addr_d  = wr_ptr_q;
        wdata_d = j_word(26'(wr_ptr_q));
        state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      full_q   <= full_d;
      err_q    <= err_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed encodings plus randomized traffic
// compared against a behavioural load model and a shadow instruction memory.
module tb_instr_encoder_loader;
  import mips_isa_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
`ifdef ENC_HALT_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_LOAD = 1, M_PAD = 2, M_RUN = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, req_valid, done;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [4:0]    req_rs, req_rt, req_rd;
  logic [15:0]   req_imm;
  logic [25:0]   req_target;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_run, err_op, full;

  int n_checks = 0;
  int n_fail   = 0;

  int m_state, m_ptr, n_writes, last_addr;
  bit m_full, m_err;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] dut_mem   [DEPTH];
  bit          model_wr  [DEPTH];

  instr_encoder_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_rd     (req_rd),
    .req_imm    (req_imm),
    .req_target (req_target),
    .done       (done),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .err_op     (err_op),
    .full       (full)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference encoding built from field weights rather than bit concatenation
  function automatic logic [31:0] ref_encode(input logic [3:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
      input logic [25:0] tgt, output bit legal);
    int unsigned w;
    int unsigned s, t, d, i, g;
    s = rs; t = rt; d = rd; i = imm; g = tgt;
    legal = 1'b1;
    case (op)
      4'd0: w = 32'h08 * 2**26 + s * 2**21 + t * 2**16 + i;
      4'd1: w = 32'h01 * 2**26 + s * 2**21 + i;
      4'd2: w = 32'h02 * 2**26 + g;
      4'd3: w = 32'h23 * 2**26 + s * 2**21 + t * 2**16 + i;
      4'd4: w = 32'h2B * 2**26 + s * 2**21 + t * 2**16 + i;
      4'd5: w = s * 2**21 + t * 2**16 + d * 2**11 + 32'h23;
      4'd6: w = s * 2**21 + t * 2**16 + d * 2**11 + 32'h27;
      4'd7: w = s * 2**21 + t * 2**16 + d * 2**11 + 32'h2B;
      4'd8: w = s * 2**21 + 32'h08;
      default: begin w = 0; legal = 1'b0; end
    endcase
    return w;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_ptr = 0; m_full = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_restart();
    m_state = M_LOAD; m_ptr = 0; m_full = 1'b0; m_err = 1'b0;
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance model, check registers
  task automatic step(input logic st, input logic v, input logic [3:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
      input logic [25:0] tgt, input logic dn);
    bit ew, legal;
    int ea;
    logic [31:0] ewd;
    start = st; req_valid = v; req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
    req_imm = imm; req_target = tgt; done = dn;
    #1;
    check_eq("req_ready", 32'(req_ready), 32'((m_state == M_LOAD) && !m_full));
    check_eq("cpu_run", 32'(cpu_run), 32'((m_state == M_RUN) && !st));
    ew = 1'b0; ea = 0; ewd = '0;
    case (m_state)
      M_IDLE, M_RUN: if (st) model_restart();
      M_LOAD: begin
        if (v && !m_full) begin
          ewd = ref_encode(op, rs, rt, rd, imm, tgt, legal);
          if (legal) begin
            ew = 1'b1; ea = m_ptr;
            if (m_ptr == DEPTH - 1) m_full = 1'b1;
            else m_ptr++;
          end else begin
            m_err = 1'b1;
          end
        end
        if (dn) m_state = (PAD_EN && !m_full) ? M_PAD : M_RUN;
      end
      default: begin
        ew = 1'b1; ea = m_ptr; ewd = 32'h0800_0000 + m_ptr;
        m_state = M_RUN;
      end
    endcase
    if (ew) begin model_mem[ea] = ewd; model_wr[ea] = 1'b1; end
    @(posedge clk);
    #1;
    check_eq("imem_we", 32'(imem_we), 32'(ew));
    if (ew) begin
      check_eq("imem_addr", 32'(imem_addr), 32'(ea));
      check_eq("imem_wdata", imem_wdata, ewd);
    end
    check_eq("full", 32'(full), 32'(m_full));
    check_eq("err_op", 32'(err_op), 32'(m_err));
    if (imem_we) begin
      dut_mem[imem_addr] = imem_wdata;
      n_writes++;
      last_addr = int'(imem_addr);
    end
    $display("cyc st=%0b v=%0b op=%0d dn=%0b -> we=%0b addr=%0d wdata=%08h rdy=%0b full=%0b err=%0b",
             st, v, op, dn, imem_we, imem_addr, imem_wdata, req_ready, full, err_op);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
  endtask

  task automatic req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    step(1'b0, 1'b1, op, rs, rt, rd, imm, tgt, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_we"}, 32'(imem_we), 32'd0);
    check_eq({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check_eq({tag, "_wdata"}, imem_wdata, 32'd0);
    check_eq({tag, "_run"}, 32'(cpu_run), 32'd0);
    check_eq({tag, "_err"}, 32'(err_op), 32'd0);
    check_eq({tag, "_full"}, 32'(full), 32'd0);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 0; req_valid = 0; done = 0; req_op = 0; req_rs = 0; req_rt = 0;
    req_rd = 0; req_imm = 0; req_target = 0; n_writes = 0; last_addr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0; dut_mem[i] = '0; model_wr[i] = 1'b0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Basic encodings, back-to-back
    step(1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
    req(OP_SUBU, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    check_eq("subu_lit", imem_wdata, 32'h0022_1823);
    req(OP_ADDI, 5'd0, 5'd1, 5'd0, 16'd5, 26'd0);
    check_eq("addi_lit", imem_wdata, 32'h2001_0005);
    req(OP_LW, 5'd2, 5'd4, 5'd0, 16'd8, 26'd0);
    check_eq("lw_lit", imem_wdata, 32'h8C44_0008);
    req(OP_NOR, 5'd8, 5'd9, 5'd7, 16'd0, 26'd0);
    check_eq("nor_lit", imem_wdata, 32'h0109_3827);
    req(OP_BLTZ, 5'd5, 5'd17, 5'd0, 16'hFFFE, 26'd0);
    check_eq("bltz_lit", imem_wdata, 32'h04A0_FFFE);
    req(OP_JR, 5'd31, 5'd3, 5'd4, 16'd0, 26'd0);
    check_eq("jr_lit", imem_wdata, 32'h03E0_0008);
    req(OP_J, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10);
    check_eq("j_lit", imem_wdata, 32'h0800_0010);
    check_eq("j_addr", 32'(imem_addr), 32'd6);

    // Illegal op: no write, err_op sticky, next word lands at the same address
    req(4'hF, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1);
    check_eq("illegal_err", 32'(err_op), 32'd1);
    req(OP_SLTU, 5'd3, 5'd4, 5'd5, 16'd0, 26'd0);
    check_eq("after_illegal_addr", 32'(imem_addr), 32'd7);
    step(1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1);
    idle();

    // Three words then done: halt pad at address 3 when enabled
    step(1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
    check_eq("restart_err_clr", 32'(err_op), 32'd0);
    for (int i = 0; i < 3; i++) req(OP_ADDI, 5'(i), 5'(i + 1), 5'd0, 16'(i), 26'd0);
    step(1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1);
    idle();
    if (PAD_EN) begin
      check_eq("pad_addr", 32'(last_addr), 32'd3);
      check_eq("pad_word", dut_mem[3], 32'h0800_0003);
    end
    idle();

    // Fill: DEPTH+2 valid requests produce exactly DEPTH writes and no wrap
    step(1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
    n_writes = 0;
    for (int i = 0; i < DEPTH + 2; i++)
      req(4'($urandom_range(0, 8)), 5'($urandom), 5'($urandom), 5'($urandom),
          16'($urandom), 26'($urandom));
    check_eq("fill_writes", 32'(n_writes), 32'(DEPTH));
    check_eq("fill_last_addr", 32'(last_addr), 32'(DEPTH - 1));
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_ready", 32'(req_ready), 32'd0);
    step(1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1);
    idle();

    // Randomized traffic including illegal ops, restarts and done pulses
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 4), 1'($urandom_range(0, 99) < 75),
           4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
           16'($urandom), 26'($urandom), 1'($urandom_range(0, 99) < 3));
    end

    // Asynchronous reset during a load clears everything, including the pending write
    step(1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
    req(OP_SW, 5'd6, 5'd7, 5'd0, 16'h1234, 26'd0);
    check_eq("pre_rst_we", 32'(imem_we), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("midload_rst");
    model_reset();
    rst = 1'b0;
    idle();
    step(1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
    req(OP_SW, 5'd6, 5'd7, 5'd0, 16'h1234, 26'd0);
    check_eq("post_rst_addr", 32'(imem_addr), 32'd0);

    for (int i = 0; i < DEPTH; i++)
      if (model_wr[i]) check_eq($sformatf("mem[%0d]", i), dut_mem[i], model_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
